offchip_mem_2ch: RTL and testbench

- Synthesizable two-channel off-chip memory model that serves the Bambu-generated top's master bus (Mout_oe_ram/Mout_we_ram/Mout_addr_ram/Mout_Wdata_ram/Mout_data_ram_size).
- Returns M_Rdata_ram and M_DataRdy, replacing the behavioural memory in the simulation harness.
- A single-port byte array is shared by both channels through round-robin arbitration, with configurable read latency and byte-lane size masking.
- A load port preloads the array before start_port is raised.

---
 rtl/offchip_mem_2ch.sv | 160 ++++++++++++++++
 tb/tb_offchip_mem_2ch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/offchip_mem_2ch.sv
// Two-channel off-chip memory model for the Bambu master bus: one shared byte array,
// round-robin arbitration, configurable read latency, byte-lane size masking and a preload port.
module offchip_mem_2ch #(
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned MEMSIZE      = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [15:0]           Mout_Wdata_ram,
    input  logic [7:0]            Mout_data_ram_size,
    output logic [15:0]           M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    input  logic                  ld_en,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [7:0]            ld_data,
    output logic [1:0]            proto_err,
    output logic                  range_err,
    output logic                  busy
);

    localparam int unsigned IDX_W    = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [3:0]  LAST_CNT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWresp, StRwait} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_rr_ptr, w_rr_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_ch;
    logic [7:0]        r_rdata;
    logic [1:0]        r_blk;
    logic [1:0]        r_proto_err;
    logic              r_range_err;
    logic [7:0]        r_mem [MEMSIZE];

    logic [1:0]        w_req;
    logic              w_gnt, w_gnt_ch, w_gnt_we, w_gnt_inr, w_ld_do, w_ld_inr;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [7:0]        w_gnt_wdata, w_gnt_mask;
    logic [3:0]        w_gnt_size;
    logic [8:0]        w_mask9;
    logic [IDX_W-1:0]  w_gnt_idx, w_ld_idx;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) >= BASE_ADDR) && ((32'(a) - BASE_ADDR) < MEMSIZE);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(32'(a) - BASE_ADDR);
    endfunction

    // Fields of whichever channel would be granted this cycle.
    always_comb begin
        w_gnt_addr  = w_gnt_ch ? Mout_addr_ram[2*ADDR_W-1:ADDR_W] : Mout_addr_ram[ADDR_W-1:0];
        w_gnt_wdata = w_gnt_ch ? Mout_Wdata_ram[15:8] : Mout_Wdata_ram[7:0];
        w_gnt_size  = w_gnt_ch ? Mout_data_ram_size[7:4] : Mout_data_ram_size[3:0];
        w_gnt_we    = Mout_we_ram[w_gnt_ch];
        w_mask9     = (9'd1 << w_gnt_size) - 9'd1;
        w_gnt_mask  = w_mask9[7:0];
        w_gnt_inr   = in_range(w_gnt_addr);
        w_gnt_idx   = to_idx(w_gnt_addr);
        w_ld_inr    = in_range(ld_addr);
        w_ld_idx    = to_idx(ld_addr);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        w_gnt_ch    = 1'b0;
        w_ld_do     = 1'b0;
        M_DataRdy   = 2'b00;
        M_Rdata_ram = 16'h0000;
        w_req       = (Mout_oe_ram ^ Mout_we_ram) & ~r_blk;
        unique case (r_state)
            StIdle: begin
                if (ld_en) begin
                    w_ld_do = 1'b1;
                end else if (w_req == 2'b11) begin
                    w_gnt    = 1'b1;
                    w_gnt_ch = r_rr_ptr;
                    w_rr_nxt = ~r_rr_ptr;
                end else if (w_req != 2'b00) begin
                    w_gnt    = 1'b1;
                    w_gnt_ch = w_req[1];
                    w_rr_nxt = ~w_req[1];
                end
                if (w_gnt) begin
                    w_state_nxt = w_gnt_we ? StWresp : StRwait;
                end
            end
            StWresp: begin
                M_DataRdy[r_ch] = 1'b1;
                w_state_nxt     = StIdle;
            end
            StRwait: begin
                if (r_cnt == LAST_CNT) begin
                    M_DataRdy[r_ch] = 1'b1;
                    if (r_ch) begin
                        M_Rdata_ram[15:8] = r_rdata;
                    end else begin
                        M_Rdata_ram[7:0] = r_rdata;
                    end
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_rr_ptr    <= 1'b0;
            r_cnt       <= 4'd0;
            r_ch        <= 1'b0;
            r_rdata     <= 8'h00;
            r_blk       <= 2'b00;
            r_proto_err <= 2'b00;
            r_range_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_cnt       <= w_cnt_nxt;
            // Requester still holds its request on the DataRdy edge.
            r_blk       <= M_DataRdy;
            r_proto_err <= r_proto_err | (Mout_oe_ram & Mout_we_ram);
            r_range_err <= r_range_err | (w_ld_do & ~w_ld_inr) | (w_gnt & ~w_gnt_inr);
            if (w_gnt) begin
                r_ch    <= w_gnt_ch;
                r_rdata <= w_gnt_inr ? (r_mem[w_gnt_idx] & w_gnt_mask) : 8'h00;
            end
        end
    end

    // Array is never reset; a write committed at the grant edge survives a later reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_ld_do && w_ld_inr) begin
                r_mem[w_ld_idx] <= ld_data;
            end else if (w_gnt && w_gnt_we && w_gnt_inr) begin
                r_mem[w_gnt_idx] <= (w_gnt_wdata & w_gnt_mask) | (r_mem[w_gnt_idx] & ~w_gnt_mask);
            end
        end
    end

    assign proto_err = r_proto_err;
    assign range_err = r_range_err;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_offchip_mem_2ch.sv
// Self-checking bench for offchip_mem_2ch: table of single-channel transfers on a
// READ_LATENCY=2 instance, hand sequences for arbitration/errors/reset, and a READ_LATENCY=1 instance.
module tb_offchip_mem_2ch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  oe_v    [2];
    logic [1:0]  we_v    [2];
    logic [13:0] addr_v  [2];
    logic [15:0] wd_v    [2];
    logic [7:0]  sz_v    [2];
    logic        lden_v  [2];
    logic [6:0]  ldaddr_v[2];
    logic [7:0]  lddata_v[2];
    logic [15:0] rdat_v  [2];
    logic [1:0]  rdy_v   [2];
    logic [1:0]  perr_v  [2];
    logic        rerr_v  [2];
    logic        busy_v  [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    offchip_mem_2ch #(.ADDR_W(7), .BASE_ADDR(0), .MEMSIZE(32), .READ_LATENCY(2)) dut (
        .clock(clk), .reset(rst),
        .Mout_oe_ram(oe_v[0]), .Mout_we_ram(we_v[0]), .Mout_addr_ram(addr_v[0]),
        .Mout_Wdata_ram(wd_v[0]), .Mout_data_ram_size(sz_v[0]),
        .M_Rdata_ram(rdat_v[0]), .M_DataRdy(rdy_v[0]),
        .ld_en(lden_v[0]), .ld_addr(ldaddr_v[0]), .ld_data(lddata_v[0]),
        .proto_err(perr_v[0]), .range_err(rerr_v[0]), .busy(busy_v[0])
    );

    offchip_mem_2ch #(.ADDR_W(7), .BASE_ADDR(0), .MEMSIZE(32), .READ_LATENCY(1)) dut1 (
        .clock(clk), .reset(rst),
        .Mout_oe_ram(oe_v[1]), .Mout_we_ram(we_v[1]), .Mout_addr_ram(addr_v[1]),
        .Mout_Wdata_ram(wd_v[1]), .Mout_data_ram_size(sz_v[1]),
        .M_Rdata_ram(rdat_v[1]), .M_DataRdy(rdy_v[1]),
        .ld_en(lden_v[1]), .ld_addr(ldaddr_v[1]), .ld_data(lddata_v[1]),
        .proto_err(perr_v[1]), .range_err(rerr_v[1]), .busy(busy_v[1])
    );

    typedef struct {
        logic       ch;
        logic       we;
        logic [6:0] addr;
        logic [7:0] wd;
        logic [3:0] sz;
        int         lat;
        logic [7:0] rd;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic ld(input int s, input logic [6:0] a, input logic [7:0] d);
        lden_v[s]   = 1'b1;
        ldaddr_v[s] = a;
        lddata_v[s] = d;
        @(posedge clk); #1;
        lden_v[s] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Single transfer; lat counts cycles from the grant cycle to DataRdy.
    task automatic xfer(input int s, input logic ch, input logic we, input logic [6:0] addr,
                        input logic [7:0] wd, input logic [3:0] sz,
                        output int lat, output logic [7:0] rd, output logic lane_ok);
        lat = -1;
        rd = 8'h00;
        lane_ok = 1'b1;
        addr_v[s][ch*7 +: 7] = addr;
        wd_v[s][ch*8 +: 8]   = wd;
        sz_v[s][ch*4 +: 4]   = sz;
        oe_v[s][ch] = ~we;
        we_v[s][ch] = we;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rdy_v[s][ch]) begin
                lat = i;
                rd = rdat_v[s][ch*8 +: 8];
                break;
            end
            if (rdat_v[s] != 16'h0) lane_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        oe_v[s][ch] = 1'b0;
        we_v[s][ch] = 1'b0;
        @(negedge clk);
        if (rdat_v[s] != 16'h0) lane_ok = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pair(input int s, input logic [6:0] a0, input logic [6:0] a1,
                        output int l0, output int l1, output logic [7:0] d0, output logic [7:0] d1);
        l0 = -1; l1 = -1; d0 = 8'h00; d1 = 8'h00;
        addr_v[s] = {a1, a0};
        sz_v[s]   = 8'h88;
        we_v[s]   = 2'b00;
        oe_v[s]   = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rdy_v[s][0] && l0 < 0) begin l0 = i; d0 = rdat_v[s][7:0]; end
            if (rdy_v[s][1] && l1 < 0) begin l1 = i; d1 = rdat_v[s][15:8]; end
            @(posedge clk); #1;
            if (l0 >= 0) oe_v[s][0] = 1'b0;
            if (l1 >= 0) oe_v[s][1] = 1'b0;
        end
        oe_v[s] = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int         lat, l0, l1, cnt, first;
        logic [7:0] rd, d0, d1;
        logic       ok;

        vt[0]  = '{1'b0, 1'b0, 7'd5,  8'h00, 4'd8,  2, 8'hA5};
        vt[1]  = '{1'b1, 1'b1, 7'd3,  8'h3C, 4'd4,  1, 8'h00};
        vt[2]  = '{1'b0, 1'b0, 7'd3,  8'h00, 4'd8,  2, 8'hFC};
        vt[3]  = '{1'b1, 1'b0, 7'd3,  8'h00, 4'd4,  2, 8'h0C};
        vt[4]  = '{1'b1, 1'b0, 7'd5,  8'h00, 4'd15, 2, 8'hA5};
        vt[5]  = '{1'b0, 1'b0, 7'd5,  8'h00, 4'd0,  2, 8'h00};
        vt[6]  = '{1'b0, 1'b1, 7'd7,  8'hAB, 4'd0,  1, 8'h00};
        vt[7]  = '{1'b1, 1'b0, 7'd7,  8'h00, 4'd8,  2, 8'h12};
        vt[8]  = '{1'b0, 1'b1, 7'd31, 8'h77, 4'd8,  1, 8'h00};
        vt[9]  = '{1'b1, 1'b0, 7'd31, 8'h00, 4'd8,  2, 8'h77};
        vt[10] = '{1'b1, 1'b1, 7'd0,  8'h81, 4'd8,  1, 8'h00};
        vt[11] = '{1'b0, 1'b0, 7'd0,  8'h00, 4'd1,  2, 8'h01};
        vt[12] = '{1'b1, 1'b1, 7'd3,  8'hA5, 4'd6,  1, 8'h00};
        vt[13] = '{1'b0, 1'b0, 7'd3,  8'h00, 4'd8,  2, 8'hE5};

        for (int s = 0; s < 2; s++) begin
            oe_v[s] = '0; we_v[s] = '0; addr_v[s] = '0; wd_v[s] = '0; sz_v[s] = '0;
            lden_v[s] = 1'b0; ldaddr_v[s] = '0; lddata_v[s] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rdy", 32'(rdy_v[0]), 32'h0);
        chk("reset_rdata", 32'(rdat_v[0]), 32'h0);
        chk("reset_busy", 32'(busy_v[0]), 32'h0);
        chk("reset_proto", 32'(perr_v[0]), 32'h0);
        chk("reset_range", 32'(rerr_v[0]), 32'h0);
        @(posedge clk); #1;

        ld(0, 7'd5, 8'hA5);
        ld(0, 7'd3, 8'hF0);
        ld(0, 7'd7, 8'h12);
        ld(0, 7'd8, 8'h99);
        ld(0, 7'd9, 8'h66);

        for (int i = 0; i < 14; i++) begin
            xfer(0, vt[i].ch, vt[i].we, vt[i].addr, vt[i].wd, vt[i].sz, lat, rd, ok);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].rd));
            chk($sformatf("vec%0d_lane_idle_zero", i), 32'(ok), 32'h1);
        end
        chk("table_range_err", 32'(rerr_v[0]), 32'h0);
        chk("table_proto_err", 32'(perr_v[0]), 32'h0);

        // Request held one cycle past DataRdy must not be re-granted.
        addr_v[0][6:0] = 7'd5; sz_v[0][3:0] = 4'd8; oe_v[0][0] = 1'b1;
        cnt = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy_v[0][0]) begin cnt++; if (first < 0) first = i; end
            @(posedge clk); #1;
            if (first >= 0 && i == first + 1) oe_v[0][0] = 1'b0;
        end
        oe_v[0][0] = 1'b0;
        chk("turnaround_first_rdy", 32'(first), 32'd2);
        chk("turnaround_rdy_count", 32'(cnt), 32'd1);

        do_reset();
        pair(0, 7'd5, 7'd3, l0, l1, d0, d1);
        chk("rr0_ch0_latency", 32'(l0), 32'd2);
        chk("rr0_ch1_latency", 32'(l1), 32'd5);
        chk("rr0_ch0_data", 32'(d0), 32'hA5);
        chk("rr0_ch1_data", 32'(d1), 32'hE5);
        xfer(0, 1'b0, 1'b0, 7'd7, 8'h00, 4'd8, lat, rd, ok);
        pair(0, 7'd5, 7'd3, l0, l1, d0, d1);
        chk("rr1_ch1_latency", 32'(l1), 32'd2);
        chk("rr1_ch0_latency", 32'(l0), 32'd5);

        xfer(0, 1'b0, 1'b0, 7'd40, 8'h00, 4'd8, lat, rd, ok);
        chk("oor_read_latency", 32'(lat), 32'd2);
        chk("oor_read_data", 32'(rd), 32'h0);
        chk("oor_read_range_err", 32'(rerr_v[0]), 32'h1);
        xfer(0, 1'b0, 1'b1, 7'd40, 8'hEE, 4'd8, lat, rd, ok);
        chk("oor_write_latency", 32'(lat), 32'd1);
        xfer(0, 1'b1, 1'b0, 7'd8, 8'h00, 4'd8, lat, rd, ok);
        chk("oor_write_discarded", 32'(rd), 32'h99);

        do_reset();
        chk("range_err_cleared", 32'(rerr_v[0]), 32'h0);
        ld(0, 7'd41, 8'h55);
        chk("oor_load_range_err", 32'(rerr_v[0]), 32'h1);
        xfer(0, 1'b0, 1'b0, 7'd9, 8'h00, 4'd8, lat, rd, ok);
        chk("oor_load_dropped", 32'(rd), 32'h66);

        // Protocol error on ch0 while ch1 keeps working.
        addr_v[0] = {7'd5, 7'd5}; sz_v[0] = 8'h88;
        oe_v[0] = 2'b11; we_v[0] = 2'b01;
        cnt = 0; l1 = -1; d1 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy_v[0][0]) cnt++;
            if (rdy_v[0][1] && l1 < 0) begin l1 = i; d1 = rdat_v[0][15:8]; end
            @(posedge clk); #1;
            if (l1 >= 0) oe_v[0][1] = 1'b0;
        end
        oe_v[0] = 2'b00; we_v[0] = 2'b00;
        chk("proto_no_rdy", 32'(cnt), 32'd0);
        chk("proto_err_value", 32'(perr_v[0]), 32'h1);
        chk("proto_ch1_latency", 32'(l1), 32'd2);
        chk("proto_ch1_data", 32'(d1), 32'hA5);
        @(posedge clk); #1;

        // Reset after a read grant aborts it.
        addr_v[0][6:0] = 7'd5; sz_v[0][3:0] = 4'd8; oe_v[0][0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; oe_v[0][0] = 1'b0;
        @(negedge clk);
        chk("abort_read_busy", 32'(busy_v[0]), 32'h0);
        chk("abort_read_rdy", 32'(rdy_v[0]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy_v[0] != 2'b00) cnt++;
            @(posedge clk); #1;
        end
        chk("abort_read_no_late_rdy", 32'(cnt), 32'd0);

        // Write committed at the grant edge survives a reset before DataRdy.
        addr_v[0][13:7] = 7'd12; wd_v[0][15:8] = 8'h4D; sz_v[0][7:4] = 4'd8; we_v[0][1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; we_v[0][1] = 1'b0;
        @(negedge clk);
        chk("abort_write_rdy", 32'(rdy_v[0]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b0, 1'b0, 7'd12, 8'h00, 4'd8, lat, rd, ok);
        chk("abort_write_persists", 32'(rd), 32'h4D);
        xfer(0, 1'b1, 1'b0, 7'd5, 8'h00, 4'd8, lat, rd, ok);
        chk("reset_keeps_mem", 32'(rd), 32'hA5);

        // READ_LATENCY=1 instance.
        ld(1, 7'd2, 8'h3E);
        xfer(1, 1'b1, 1'b0, 7'd2, 8'h00, 4'd8, lat, rd, ok);
        chk("rl1_read_latency", 32'(lat), 32'd1);
        chk("rl1_read_data", 32'(rd), 32'h3E);
        xfer(1, 1'b0, 1'b1, 7'd2, 8'hC3, 4'd8, lat, rd, ok);
        chk("rl1_write_latency", 32'(lat), 32'd1);
        xfer(1, 1'b0, 1'b0, 7'd2, 8'h00, 4'd4, lat, rd, ok);
        chk("rl1_read2_latency", 32'(lat), 32'd1);
        chk("rl1_read2_data", 32'(rd), 32'h03);
        chk("rl1_lane_idle_zero", 32'(ok), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
